// File: rtl/mem_arbiter_pkg.sv
// Shared types for the core memory-bus arbiter: owner/state enums, transfer
// size codes and the latched bus request record.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } mem_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    msize_t                size;
    logic [MEM_STRB_W-1:0] strobe;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic mem_owner_t other_side(input mem_owner_t side);
    return (side == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the core memory bus between instruction fetch and load/store, one
// transaction at a time, round-robin under contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              dreq_valid,
  input  logic              dreq_write,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [STRB_W-1:0] dreq_strobe,
  input  logic [DATA_W-1:0] dreq_wdata,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              oreq_valid,
  input  logic              oreq_ready,
  output logic              oreq_write,
  output logic [ADDR_W-1:0] oreq_addr,
  output logic [2:0]        oreq_size,
  output logic [STRB_W-1:0] oreq_strobe,
  output logic [DATA_W-1:0] oreq_wdata,
  input  logic              oresp_valid,
  input  logic [DATA_W-1:0] oresp_data
);

  arb_state_t        state_q;
  mem_owner_t        owner_q;
  mem_owner_t        last_grant_q;
  mem_req_t          req_q;
  logic              oreq_valid_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              resp_s;
  logic              grant_d_s;
  logic              i_ok_s;
  logic              d_ok_s;
  mem_req_t          ireq_s;
  mem_req_t          dreq_s;

  // Response acceptance, grant choice and the completion pulses.
  always_comb begin
    resp_s    = 1'b0;
    grant_d_s = 1'b0;
    // A response in REQ counts only when the bus takes the request that same cycle.
    if (!reset && oresp_valid &&
        ((state_q == ARB_WAIT) || ((state_q == ARB_REQ) && oreq_ready))) begin
      resp_s = 1'b1;
    end else begin
      resp_s = 1'b0;
    end
    if (dreq_valid && (!ireq_valid || (other_side(last_grant_q) == OWN_D))) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
    // A withdrawn request means the owner was flushed; the response is dropped.
    i_ok_s = resp_s && (owner_q == OWN_I) && ireq_valid;
    d_ok_s = resp_s && (owner_q == OWN_D) && dreq_valid;

    ireq_s = '{write: 1'b0, addr: MEM_ADDR_W'(ireq_addr), size: MSIZE4,
               strobe: '0, wdata: '0};
    dreq_s = '{write: dreq_write, addr: MEM_ADDR_W'(dreq_addr), size: msize_t'(dreq_size),
               strobe: MEM_STRB_W'(dreq_strobe), wdata: MEM_DATA_W'(dreq_wdata)};
  end

  // Transaction sequencer with the request latch and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      req_q        <= '0;
      oreq_valid_q <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_d_s) begin
            req_q        <= dreq_s;
            owner_q      <= OWN_D;
            last_grant_q <= OWN_D;
            oreq_valid_q <= 1'b1;
            state_q      <= ARB_REQ;
          end else if (ireq_valid) begin
            req_q        <= ireq_s;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            oreq_valid_q <= 1'b1;
            state_q      <= ARB_REQ;
          end else begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_REQ: begin
          if (oreq_ready) begin
            oreq_valid_q <= 1'b0;
            state_q      <= resp_s ? ARB_IDLE : ARB_WAIT;
          end else begin
            state_q <= ARB_REQ;
          end
        end
        ARB_WAIT: begin
          if (resp_s) begin
            state_q <= ARB_IDLE;
          end else begin
            state_q <= ARB_WAIT;
          end
        end
        default: begin
          state_q      <= ARB_IDLE;
          oreq_valid_q <= 1'b0;
        end
      endcase
      if (i_ok_s) begin
        i_rdata_q <= oresp_data;
      end else begin
        i_rdata_q <= i_rdata_q;
      end
      if (d_ok_s) begin
        d_rdata_q <= oresp_data;
      end else begin
        d_rdata_q <= d_rdata_q;
      end
    end
  end

  assign oreq_valid  = oreq_valid_q;
  assign oreq_write  = req_q.write;
  assign oreq_addr   = req_q.addr[ADDR_W-1:0];
  assign oreq_size   = req_q.size;
  assign oreq_strobe = req_q.strobe[STRB_W-1:0];
  assign oreq_wdata  = req_q.wdata[DATA_W-1:0];

  assign i_data_ok = i_ok_s;
  assign d_data_ok = d_ok_s;
  assign i_rdata   = i_ok_s ? oresp_data : i_rdata_q;
  assign d_rdata   = d_ok_s ? oresp_data : d_rdata_q;

endmodule
